// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the divider: operand width, operation codes,
// divider FSM states and a conditional two's-complement negate helper.
package rv32_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } div_state_e;

  // Negate v when neg is set; used both for operand magnitudes and sign fix-up.
  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, emit one quotient bit.
module div_step
  import rv32_pkg::*;
(
  input  logic [XLEN:0]   rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] dvs_i,
  output logic [XLEN:0]   rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN+1:0] shifted;
  logic [XLEN+1:0] trial;
  logic            take;

  // One guard bit above the 33-bit remainder so the borrow is always visible.
  assign shifted = {rem_i, quo_i[XLEN-1]};
  assign trial   = shifted - {2'b00, dvs_i};
  assign take    = ~trial[XLEN+1];
  assign rem_o   = take ? trial[XLEN:0] : shifted[XLEN:0];
  assign quo_o   = {quo_i[XLEN-2:0], take};

endmodule

// File: rtl/div_unit.sv
// Iterative 32-bit RV32M divider (DIV/DIVU/REM/REMU), one quotient bit per
// clock, with single-cycle handling of divide-by-zero and signed overflow.
module div_unit
  import rv32_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  input  logic [4:0]       rd_in,
  input  logic             kill,
  output logic             busy,
  output logic             done,
  output logic [XLEN-1:0]  result,
  output logic [4:0]       rd_out,
  output logic             we,
  output div_state_e       dbg_state
);

  // Handshake: start is a request sampled only in IDLE (no ready; busy tells the
  // issuer to hold off); done is a one-cycle valid for result/rd_out with no ready.
  div_state_e      state_q, state_d;
  div_op_e         op_in, op_q;
  logic [XLEN:0]   rem_q, step_rem;
  logic [XLEN-1:0] quo_q, dvs_q, result_q, step_quo;
  logic [XLEN-1:0] special_res, final_res;
  logic [4:0]      rd_q;
  logic [5:0]      cnt_q;
  logic            neg_q;
  logic            is_signed, is_rem, a_neg, b_neg, div_zero, ovf, special;
  logic            accept, last_step;

  assign op_in     = div_op_e'(op);
  assign is_signed = (op_in == DIV) || (op_in == REM);
  assign is_rem    = (op_in == REM) || (op_in == REMU);
  assign a_neg     = is_signed & a[XLEN-1];
  assign b_neg     = is_signed & b[XLEN-1];
  assign div_zero  = (b == '0);
  assign ovf       = is_signed && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  assign special   = div_zero | ovf;
  assign accept    = (state_q == S_IDLE) && start && !kill;
  assign last_step = (state_q == S_BUSY) && (cnt_q == 6'd31);

  always_comb begin
    special_res = '0;
    if (div_zero)  special_res = is_rem ? a : '1;
    else if (ovf)  special_res = is_rem ? '0 : 32'h8000_0000;
  end

  div_step u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  // neg_q already encodes which operand signs matter for the latched op.
  assign final_res = ((op_q == REM) || (op_q == REMU)) ? neg_if(step_rem[XLEN-1:0], neg_q)
                                                       : neg_if(step_quo, neg_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (kill && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (accept) state_d = special ? S_DONE : S_BUSY;
        S_BUSY:  if (last_step) state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
    we   = (state_q == S_DONE) && (rd_q != 5'd0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q     <= DIV;
      rd_q     <= '0;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else if (accept) begin
      op_q  <= op_in;
      rd_q  <= rd_in;
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= neg_if(a, a_neg);
      dvs_q <= neg_if(b, b_neg);
      neg_q <= (op_in == DIV) ? (a_neg ^ b_neg) : a_neg;
      if (special) result_q <= special_res;
    end else if ((state_q == S_BUSY) && !kill) begin
      rem_q <= step_rem;
      quo_q <= step_quo;
      cnt_q <= cnt_q + 6'd1;
      if (last_step) result_q <= final_res;
    end
  end

  assign result    = result_q;
  assign rd_out    = rd_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_div_unit.sv
// Randomised and directed bench for div_unit against a plain-arithmetic
// RV32M division model with a result/rd/latency expectation queue.
module tb_div_unit;
  import rv32_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [4:0]  rd_in = '0;
  logic        busy, done, we;
  logic [31:0] result;
  logic [4:0]  rd_out;
  div_state_e  dbg_state;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  logic [31:0] exp_q[$];
  logic [4:0]  exp_rd_q[$];
  int          exp_edge_q[$];

  logic        hold_valid = 1'b0;
  logic [31:0] hold_res = '0;
  logic [4:0]  hold_rd = '0;
  logic        prev_done = 1'b0;
  logic [31:0] cur_res;
  logic [4:0]  cur_rd;
  int          cur_edge;

  div_unit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .rd_in     (rd_in),
    .kill      (kill),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .rd_out    (rd_out),
    .we        (we),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    int sx, sy;
    sx = x;
    sy = y;
    if (y == 32'd0) return ((o == DIV) || (o == DIVU)) ? 32'hFFFF_FFFF : x;
    if (((o == DIV) || (o == REM)) && (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF))
      return (o == DIV) ? 32'h8000_0000 : 32'd0;
    case (o)
      DIV:     return sx / sy;
      DIVU:    return x / y;
      REM:     return sx % sy;
      default: return x % y;
    endcase
  endfunction

  function automatic bit is_special(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    return (y == 32'd0) ||
           (((o == DIV) || (o == REM)) && (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst) begin
      if (done) begin
        check("done_single_cycle", prev_done, 0);
        check("busy_in_done", busy, 1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done result=%h expected no done", result);
        end else begin
          cur_res  = exp_q.pop_front();
          cur_rd   = exp_rd_q.pop_front();
          cur_edge = exp_edge_q.pop_front();
          check("result", result, cur_res);
          check("rd_out", rd_out, cur_rd);
          check("we", we, cur_rd != 5'd0);
          check("done_edge", edge_cnt, cur_edge);
          hold_res   = cur_res;
          hold_rd    = cur_rd;
          hold_valid = 1'b1;
        end
      end else begin
        check("we_without_done", we, 0);
        if (hold_valid) begin
          check("result_hold", result, hold_res);
          check("rd_out_hold", rd_out, hold_rd);
        end
      end
      prev_done = done;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                       input logic [4:0] r, input bit track);
    @(posedge clk); #1;
    start = 1'b1; op = o; a = av; b = bv; rd_in = r;
    @(posedge clk); #1;
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom; rd_in = 5'($urandom);
    hold_valid = 1'b0;
    if (track) begin
      exp_q.push_back(ref_div(o, av, bv));
      exp_rd_q.push_back(r);
      exp_edge_q.push_back(edge_cnt + (is_special(o, av, bv) ? 0 : 32));
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((exp_q.size() != 0) && (n < 100)) begin
      @(negedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout pending=%0d expected=0", exp_q.size());
      exp_q.delete();
      exp_rd_q.delete();
      exp_edge_q.delete();
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_we"}, we, 0);
    check({tag, "_result"}, result, 0);
    check({tag, "_rd_out"}, rd_out, 0);
    check({tag, "_state"}, dbg_state, S_IDLE);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0]  o;
    logic [31:0] x, y;

    // hand-computed pins of the model
    check("pin_divu", ref_div(DIVU, 32'd100, 32'd7), 32'd14);
    check("pin_remu", ref_div(REMU, 32'd100, 32'd7), 32'd2);
    check("pin_div_neg", ref_div(DIV, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    check("pin_rem_neg", ref_div(REM, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    check("pin_divu_zero", ref_div(DIVU, 32'd5, 32'd0), 32'hFFFF_FFFF);
    check("pin_rem_zero", ref_div(REM, 32'd5, 32'd0), 32'd5);
    check("pin_div_ovf", ref_div(DIV, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
    check("pin_rem_ovf", ref_div(REM, 32'h8000_0000, 32'hFFFF_FFFF), 32'd0);

    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b1;

    // directed cases
    issue(DIVU, 32'd100, 32'd7, 5'd5, 1);              wait_done();
    issue(REMU, 32'd100, 32'd7, 5'd6, 1);              wait_done();
    issue(DIV,  32'hFFFF_FFF9, 32'd2, 5'd7, 1);        wait_done();
    issue(REM,  32'hFFFF_FFF9, 32'd2, 5'd8, 1);        wait_done();
    issue(DIVU, 32'd5, 32'd0, 5'd9, 1);                wait_done();
    issue(REM,  32'd5, 32'd0, 5'd10, 1);               wait_done();
    issue(DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1); wait_done();
    issue(REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1); wait_done();
    issue(DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1); wait_done();
    issue(DIVU, 32'd100, 32'd7, 5'd0, 1);              wait_done();

    // start during BUSY is ignored
    issue(DIVU, 32'd1000, 32'd3, 5'd14, 1);
    repeat (9) @(posedge clk);
    #1;
    start = 1'b1; op = REMU; a = 32'd77; b = 32'd5; rd_in = 5'd15;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();
    repeat (40) @(posedge clk);

    // kill in BUSY aborts with no done
    issue(DIV, 32'hFFFF_FC18, 32'd7, 5'd16, 0);
    repeat (14) @(posedge clk);
    #1;
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    check("kill_busy", busy, 0);
    check("kill_state", dbg_state, S_IDLE);
    repeat (40) @(posedge clk);

    // start together with kill in IDLE is ignored
    @(posedge clk); #1;
    start = 1'b1; kill = 1'b1; op = DIVU; a = 32'd9; b = 32'd3; rd_in = 5'd17;
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0;
    check("start_kill_busy", busy, 0);
    repeat (5) @(posedge clk);

    // asynchronous reset mid-operation
    issue(DIVU, 32'd12345, 32'd67, 5'd18, 0);
    repeat (19) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_outputs_zero("midreset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    issue(REM, 32'hFFFF_FF9C, 32'd7, 5'd19, 1);        wait_done();

    // randomised operations
    for (int i = 0; i < 60; i++) begin
      o = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: begin x = $urandom; y = 32'd0; end
        1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        2: begin x = $urandom_range(0, 200); y = $urandom_range(1, 20); end
        3: begin x = $urandom; y = $urandom; end
        4: begin
          x = -$urandom_range(1, 5000);
          y = $urandom_range(1, 50);
          if ($urandom_range(0, 1) == 1) y = -y;
        end
        default: begin x = $urandom; y = $urandom_range(1, 1000); end
      endcase
      issue(o, x, y, 5'($urandom_range(0, 31)), 1);
      wait_done();
    end

    repeat (5) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-004 SHALL have port op, input, 2 bits: div_op_e operation, DIV=00, DIVU=01, REM=10, REMU=11.
REQ-005 SHALL have port a, input, 32 bits: dividend, taken from register-file RD1.
REQ-006 SHALL have port b, input, 32 bits: divisor, taken from register-file RD2.
REQ-007 SHALL have port rd_in, input, 5 bits: destination register index.
REQ-008 SHALL have port kill, input, 1 bit: pipeline flush; aborts the operation in flight.
REQ-009 SHALL have port busy, output, 1 bit: high in BUSY and DONE.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse; result and rd_out are valid while it is high.
REQ-011 SHALL have port result, output, 32 bits: quotient or remainder, feeding register-file WD3.
REQ-012 SHALL have port rd_out, output, 5 bits: latched rd_in, feeding register-file rd.
REQ-013 SHALL have port we, output, 1 bit: write enable to register-file WE3.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-015 SHALL accept start only in IDLE, latching op, a, b and rd_in on that edge (E0); start in BUSY or DONE is ignored.
REQ-016 SHALL handle b==0 at E0 by going IDLE->DONE: quotient 0xFFFFFFFF for DIV/DIVU; remainder = a for REM/REMU.
REQ-017 SHALL handle signed overflow (DIV/REM, a=0x80000000, b=0xFFFFFFFF) at E0 by going IDLE->DONE: DIV gives 0x80000000, REM gives 0.
REQ-018 SHALL otherwise go IDLE->BUSY at E0, latching operand magnitudes (two's-complement absolute value for DIV/REM) and clearing a 6-bit iteration counter.
REQ-019 SHALL perform one restoring shift-subtract step per edge in BUSY using a 33-bit partial remainder, for exactly 32 steps (E1..E32).
REQ-020 SHALL, on E32, register the sign-corrected result and go to DONE: quotient negated if sign(a)!=sign(b) for DIV; remainder takes sign(a) for REM.
REQ-021 SHALL hold done high for exactly the single cycle in DONE, then return to IDLE on the next edge; normal latency from E0 to done high is 32 cycles, special cases 1 cycle.
REQ-022 SHALL assert we = done AND (rd_out != 0).
REQ-023 SHALL hold result and rd_out stable after DONE until the next accepted start.
REQ-024 SHALL, when kill is high on an edge in BUSY or DONE, go to IDLE with no done or we pulse; kill has priority over every other transition.
REQ-025 SHALL ignore a start that arrives together with kill in IDLE.

Reset
REQ-026 SHALL, while rst is low, immediately force state=IDLE and busy=0, done=0, we=0, result=0, rd_out=0, counter=0 and all datapath registers to 0.
REQ-027 SHALL, when reset is applied mid-operation, discard that operation; the first start after reset release is accepted normally.

Structure
REQ-028 SHALL place the div_op_e enum and XLEN=32 in shared package rv32_pkg.
REQ-029 SHALL use exactly one sub-module, div_step: combinational single iteration (shift, trial subtract, quotient bit).

Verification
REQ-030 SHALL cover DIVU a=100, b=7 -> done high 32 cycles after E0, result=14; REMU same operands -> result=2.
REQ-031 SHALL cover DIV a=-7 (0xFFFFFFF9), b=2 -> result=0xFFFFFFFD; REM same operands -> result=0xFFFFFFFF.
REQ-032 SHALL cover DIVU a=5, b=0 -> done 1 cycle after E0, result=0xFFFFFFFF; REM a=5, b=0 -> result=5.
REQ-033 SHALL cover DIV a=0x80000000, b=0xFFFFFFFF -> result=0x80000000 after 1 cycle; REM same operands -> result=0.
REQ-034 SHALL cover start pulsed at cycle 10 of BUSY -> ignored, with the original result delivered; kill at cycle 15 -> IDLE, done never asserted.
REQ-035 SHALL cover rd_in=0 -> done pulses with we=0; rst low at cycle 20 -> all outputs 0 immediately and the next start completes correctly.
